// File: rtl/double_buffer_pkg.sv
// Shared constants and helpers for the FIFO-to-stream reader and its
// two-entry skid buffer.
package double_buffer_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int RD_LATENCY = 1;
   localparam int BUF_DEPTH  = 2;

   typedef logic [1:0] occ_t;

   // A new read may be issued only if the word it returns is guaranteed a slot.
   function automatic logic has_credit(input occ_t count, input logic inflight,
                                       input logic pop);
      return (int'(count) + int'(inflight) - int'(pop)) < BUF_DEPTH;
   endfunction

endpackage

// File: rtl/skid_buffer_2.sv
// Two-entry in-order buffer: push writes the tail, pop retires the head,
// and a simultaneous push/pop keeps the occupancy unchanged.
module skid_buffer_2
   import double_buffer_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic [DATA_W-1:0] i_data,
   output occ_t              o_count,
   output logic [DATA_W-1:0] o_head
);

   logic [DATA_W-1:0] r_mem [BUF_DEPTH];
   logic              r_wr_ptr;
   logic              r_rd_ptr;
   occ_t              r_count;

   // NOTE: the storage array has no reset; only pointers and count do, since
   // an entry is never read before it has been written.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_data;
   end

   // NOTE: all state here uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= ~r_wr_ptr;
         if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
         r_count <= r_count + occ_t'(i_push) - occ_t'(i_pop);
      end
   end

   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Pulls words from a 1-cycle-latency FIFO into a two-entry buffer and
// presents them as a valid/ready stream with per-frame last markers.
module fifo_stream_reader
   import double_buffer_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int FRAME_LEN = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_dout,
   input  logic              fifo_valid,
   output logic              fifo_rd,
   input  logic              stop,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic              busy,
   output logic              overflow_err
);

   localparam int               CNT_W     = $clog2(FRAME_LEN);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);

   logic [RD_LATENCY-1:0] r_rd_pipe;
   logic [CNT_W-1:0]      r_beat_cnt;
   logic                  r_overflow;

   occ_t              w_count;
   logic [DATA_W-1:0] w_head;
   logic              w_inflight;
   logic              w_nonempty;
   logic              w_pop;
   logic              w_drop;
   logic              w_push;

   assign w_inflight = |r_rd_pipe;
   assign w_nonempty = (w_count != '0) && !reset;
   assign w_pop      = w_nonempty && m_ready;

   // A returning word with nowhere to go is dropped; reset discards stragglers.
   assign w_drop = fifo_valid && !reset && (w_count == occ_t'(BUF_DEPTH)) && !w_pop;
   assign w_push = fifo_valid && !reset && !w_drop;

   skid_buffer_2 #(
      .DATA_W (DATA_W)
   ) u_buf (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (fifo_dout),
      .o_count (w_count),
      .o_head  (w_head)
   );

   assign fifo_rd = !reset && !stop && !fifo_empty && has_credit(w_count, w_inflight, w_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_pipe  <= '0;
         r_beat_cnt <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_rd_pipe <= RD_LATENCY'({r_rd_pipe, fifo_rd});
         if (w_pop) r_beat_cnt <= (r_beat_cnt == LAST_BEAT) ? '0 : r_beat_cnt + CNT_W'(1);
         if (w_drop) r_overflow <= 1'b1;
      end
   end

   assign m_valid      = w_nonempty;
   assign m_data       = w_nonempty ? w_head : '0;
   assign m_last       = w_nonempty && (r_beat_cnt == LAST_BEAT);
   assign busy         = !reset && ((w_count != '0) || w_inflight);
   assign overflow_err = r_overflow && !reset;

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits.
REQ-002 SHALL have parameter FRAME_LEN, default 1024, beats per frame; legal range 2..65536.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port fifo_empty  input  1  upstream FIFO empty flag.
REQ-006 SHALL have port fifo_dout  input  DATA_W  upstream FIFO read data, meaningful only when fifo_valid=1.
REQ-007 SHALL have port fifo_valid  input  1  read data valid, exactly one cycle after each fifo_rd.
REQ-008 SHALL have port fifo_rd  output  1  upstream FIFO read enable.
REQ-009 SHALL have port stop  input  1  when high, no new reads are issued.
REQ-010 SHALL have port m_data  output  DATA_W  stream data.
REQ-011 SHALL have port m_valid  output  1  stream valid.
REQ-012 SHALL have port m_ready  input  1  stream ready.
REQ-013 SHALL have port m_last  output  1  marks the final beat of each frame.
REQ-014 SHALL have port busy  output  1  high while any word is buffered or in flight.
REQ-015 SHALL have port overflow_err  output  1  sticky error flag.

Function
REQ-016 SHALL hold words in a 2-entry in-order buffer; count = occupancy (0..2).
REQ-017 SHALL track inflight (0/1): set on the cycle fifo_rd=1, cleared on the following cycle.
REQ-018 SHALL define pop = m_valid && m_ready.
REQ-019 SHALL drive fifo_rd = !stop && !fifo_empty && (count + inflight - pop) < 2, combinationally; the m_ready-to-fifo_rd path is permitted.
REQ-020 SHALL write fifo_dout into the buffer tail on every cycle fifo_valid=1.
REQ-021 SHALL drive m_valid = (count != 0) and m_data = head entry; no extra latency.
REQ-022 SHALL keep m_data stable while m_valid=1 and m_ready=0.
REQ-023 SHALL support a simultaneous push and pop in one cycle with count unchanged and order preserved.
REQ-024 SHALL sustain one beat per clock when fifo_empty=0, stop=0 and m_ready=1 continuously.
REQ-025 SHALL keep a beat counter beat_cnt of width $clog2(FRAME_LEN), incremented on pop and wrapping to 0 after FRAME_LEN-1.
REQ-026 SHALL drive m_last = m_valid && (beat_cnt == FRAME_LEN-1).
REQ-027 SHALL let stop block only new reads; buffered and in-flight words still drain.
REQ-028 SHALL set overflow_err when fifo_valid=1 with count=2 and pop=0, drop that word, and hold the flag until reset.
REQ-029 SHALL drive busy = (count != 0) || inflight.

Reset
REQ-030 SHALL, while reset=1, force fifo_rd=0, m_valid=0, m_last=0, busy=0, overflow_err=0, m_data=0.
REQ-031 SHALL clear count, inflight and beat_cnt on reset; reset mid-frame restarts framing at beat 0.
REQ-032 SHALL ignore fifo_valid during reset; a word from a read issued before reset is discarded.

Structure
REQ-033 SHALL take DATA_W default and the FIFO read-latency constant (1) from the shared double_buffer_pkg.
REQ-034 SHALL implement the 2-entry buffer as sub-module skid_buffer_2 (push, pop, count, head).
REQ-035 SHALL keep read-credit logic and beat counter in fifo_stream_reader top.

Verification
REQ-036 Bench SHALL cover streaming: FIFO preloaded 0..9, m_ready=1 -> m_data 0..9 on 10 consecutive cycles, first beat 2 cycles after reset release.
REQ-037 Bench SHALL cover backpressure: m_ready=0 for 5 cycles mid-stream -> at most 2 reads issued, m_data frozen, no loss or duplication, overflow_err=0.
REQ-038 Bench SHALL cover framing: FRAME_LEN=4, 8 words -> m_last high on beats 3 and 7 only.
REQ-039 Bench SHALL cover stop: stop=1 with count=1, inflight=1 -> fifo_rd=0, both words delivered, busy falls, no further beats until stop=0.
REQ-040 Bench SHALL cover underflow: fifo_empty toggling every cycle -> fifo_rd never asserted while fifo_empty=1, output order intact.
REQ-041 Bench SHALL cover reset: reset at beat 2 of a frame with buffer full -> all outputs 0 next cycle, next frame m_last after FRAME_LEN beats.
